phase_sequencer: RTL and testbench

Synthesizable, parametrised multi-phase clock-enable generator for the processor core, replacing delay-based clock shaping. From the single system clock it produces `NUM_PHASES` non-overlapping one-hot phase levels and first-cycle strobes, each phase lasting a programmable number of clocks. It supports free-run, graceful halt and single-step. It sits between the top-level clock/reset and the datapath stage enables.

---
 rtl/phase_sequencer_pkg.sv | 13 +
 rtl/phase_sequencer_counter.sv | 30 +++
 rtl/phase_sequencer.sv | 94 +++++++++
 tb/tb_phase_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the multi-phase clock-enable sequencer.
package phase_sequencer_pkg;

  localparam int NUM_PHASES_DEF = 4;
  localparam int DIV_WIDTH_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

endpackage

// File: rtl/phase_sequencer_counter.sv
// Loadable down-counter timing one phase; zero_o marks the last clock of the phase.
module phase_counter #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clock_in_i,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic                 dec_i,
  input  logic [DIV_WIDTH-1:0] load_val_i,
  output logic                 zero_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock_in_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase clock-enable generator: free-run, graceful halt and single-step,
// with every output registered one clock behind the internal sequencing state.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASES = NUM_PHASES_DEF,
  parameter int DIV_WIDTH  = DIV_WIDTH_DEF
) (
  input  logic                  clock_in_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  step_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  output logic [NUM_PHASES-1:0] phase_active_o,
  output logic [NUM_PHASES-1:0] phase_strobe_o,
  output logic                  cycle_done_o,
  output logic                  busy_o
);

  localparam logic [NUM_PHASES-1:0] PH0 = {{(NUM_PHASES-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [NUM_PHASES-1:0] phase_q, phase_d;
  logic                  first_q, first_d;
  logic                  cnt_zero, cnt_load, cnt_dec;
  logic                  is_busy, last_clk;

  assign is_busy  = (state_q != ST_IDLE);
  assign last_clk = is_busy && cnt_zero && phase_q[NUM_PHASES-1];
  assign cnt_dec  = is_busy && !cnt_zero;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    first_d  = 1'b0;
    cnt_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i || step_i) begin
          state_d  = enable_i ? ST_RUN : ST_STEP;
          phase_d  = PH0;
          first_d  = 1'b1;
          cnt_load = 1'b1;
        end
      end
      default: begin
        if (cnt_zero) begin
          if (!phase_q[NUM_PHASES-1]) begin
            phase_d  = {phase_q[NUM_PHASES-2:0], 1'b0};
            first_d  = 1'b1;
            cnt_load = 1'b1;
          end else if ((state_q == ST_RUN) && enable_i) begin
            phase_d  = PH0;
            first_d  = 1'b1;
            cnt_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            phase_d = '0;
          end
        end
      end
    endcase
  end

  phase_counter #(.DIV_WIDTH(DIV_WIDTH)) u_phase_counter (
    .clock_in_i (clock_in_i),
    .reset_i    (reset_i),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (div_i),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clock_in_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      phase_q        <= '0;
      first_q        <= 1'b0;
      phase_active_o <= '0;
      phase_strobe_o <= '0;
      cycle_done_o   <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      first_q        <= first_d;
      phase_active_o <= is_busy ? phase_q : '0;
      phase_strobe_o <= (is_busy && first_q) ? phase_q : '0;
      cycle_done_o   <= last_clk;
      busy_o         <= is_busy;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: vector table, directed corner sequences
// and randomized stimulus against a phase/elapsed-clock reference model.
module tb_phase_sequencer;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         step;
  logic [W-1:0] div;
  logic [N-1:0] phase_active;
  logic [N-1:0] phase_strobe;
  logic         cycle_done;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  // model: mode 0 idle, 1 run, 2 step; p = phase index, t = clocks elapsed in phase
  int m_mode, m_p, m_t, m_len;
  logic [N-1:0] e_act, e_stb;
  logic         e_done, e_busy;

  always #5 clk = ~clk;

  phase_sequencer #(.NUM_PHASES(N), .DIV_WIDTH(W)) dut (
    .clock_in_i     (clk),
    .reset_i        (reset),
    .enable_i       (enable),
    .step_i         (step),
    .div_i          (div),
    .phase_active_o (phase_active),
    .phase_strobe_o (phase_strobe),
    .cycle_done_o   (cycle_done),
    .busy_o         (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_p = 0; m_t = 0; m_len = 1;
    e_act = '0; e_stb = '0; e_done = 1'b0; e_busy = 1'b0;
  endtask

  // Outputs seen after an edge reflect the sequencing state held before it.
  task automatic model_edge(input logic en, input logic st, input int dv);
    if (m_mode == 0) begin
      e_act = '0; e_stb = '0; e_done = 1'b0; e_busy = 1'b0;
    end else begin
      e_act  = N'(1 << m_p);
      e_stb  = (m_t == 0) ? e_act : '0;
      e_done = (m_p == N-1) && (m_t == m_len-1);
      e_busy = 1'b1;
    end
    if (m_mode == 0) begin
      if (en || st) begin
        m_mode = en ? 1 : 2; m_p = 0; m_t = 0; m_len = dv + 1;
      end
    end else if (m_t == m_len-1) begin
      if (m_p < N-1) begin
        m_p++; m_t = 0; m_len = dv + 1;
      end else if (m_mode == 1 && en) begin
        m_p = 0; m_t = 0; m_len = dv + 1;
      end else begin
        m_mode = 0;
      end
    end else begin
      m_t++;
    end
  endtask

  task automatic tick(input logic en, input logic st, input int dv);
    enable = en; step = st; div = W'(dv);
    @(posedge clk);
    model_edge(en, st, dv);
    @(negedge clk);
    chk("phase_active", 32'(phase_active), 32'(e_act));
    chk("phase_strobe", 32'(phase_strobe), 32'(e_stb));
    chk("cycle_done", 32'(cycle_done), 32'(e_done));
    chk("busy", 32'(busy), 32'(e_busy));
    if (busy) chk("onehot_active", 32'($onehot(phase_active)), 32'd1);
    chk("strobe_subset", 32'(phase_strobe & ~phase_active), 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && busy; i++) tick(1'b0, 1'b0, 0);
    chk("drain_to_idle", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic         en;
    logic         st;
    int           dv;
    logic [N-1:0] act;
    logic [N-1:0] stb;
    logic         done;
    logic         bsy;
  } vec_t;

  vec_t vt[7];

  initial begin
    int last, nd, c1, c2, c3, prev_done;
    logic en_r;

    vt[0] = '{1'b0, 1'b1, 0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 0, 4'b0001, 4'b0001, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b1, 0, 4'b0010, 4'b0010, 1'b0, 1'b1};
    vt[3] = '{1'b0, 1'b0, 0, 4'b0100, 4'b0100, 1'b0, 1'b1};
    vt[4] = '{1'b0, 1'b1, 0, 4'b1000, 4'b1000, 1'b1, 1'b1};
    vt[5] = '{1'b0, 1'b0, 0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b0, 0, 4'b0000, 4'b0000, 1'b0, 1'b0};

    reset = 1'b1; enable = 1'b0; step = 1'b0; div = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_active", 32'(phase_active), 32'd0);
    chk("reset_strobe", 32'(phase_strobe), 32'd0);
    chk("reset_done", 32'(cycle_done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // single step, div=0, extra step pulses ignored
    for (int i = 0; i < 7; i++) begin
      tick(vt[i].en, vt[i].st, vt[i].dv);
      chk("tbl_active", 32'(phase_active), 32'(vt[i].act));
      chk("tbl_strobe", 32'(phase_strobe), 32'(vt[i].stb));
      chk("tbl_done", 32'(cycle_done), 32'(vt[i].done));
      chk("tbl_busy", 32'(busy), 32'(vt[i].bsy));
    end

    // free run, div=2: cycle_done every 12 clocks
    last = -1; nd = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b0, 2);
      if (cycle_done) begin
        if (last >= 0) chk("free_run_period", 32'(i - last), 32'd12);
        last = i; nd++;
      end
    end
    chk("free_run_done_count", 32'(nd), 32'd3);
    drain();

    // graceful halt: enable dropped during phase 1
    tick(1'b1, 1'b0, 1);
    tick(1'b1, 1'b0, 1);
    tick(1'b1, 1'b0, 1);
    nd = 0; prev_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1);
      if (prev_done != 0) begin
        chk("halt_busy_after_done", 32'(busy), 32'd0);
        chk("halt_active_after_done", 32'(phase_active), 32'd0);
      end
      prev_done = int'(cycle_done);
      if (cycle_done) nd++;
    end
    chk("halt_done_count", 32'(nd), 32'd1);

    // div changed from 3 to 0 in the middle of phase 1
    tick(1'b1, 1'b0, 3);
    c1 = 0; c2 = 0; c3 = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, (c1 >= 2) ? 0 : 3);
      if (phase_active == 4'b0010) c1++;
      if (phase_active == 4'b0100) c2++;
      if (phase_active == 4'b1000) c3++;
    end
    chk("divchg_phase1_len", 32'(c1), 32'd4);
    chk("divchg_phase2_len", 32'(c2), 32'd1);
    chk("divchg_phase3_len", 32'(c3), 32'd1);
    drain();

    // async reset in the middle of phase 2
    tick(1'b1, 1'b0, 1);
    for (int i = 0; i < 20 && phase_active != 4'b0100; i++) tick(1'b1, 1'b0, 1);
    chk("reach_phase2", 32'(phase_active), 32'h4);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_active", 32'(phase_active), 32'd0);
    chk("async_rst_strobe", 32'(phase_strobe), 32'd0);
    chk("async_rst_done", 32'(cycle_done), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    #1 reset = 1'b0;
    model_reset();
    tick(1'b1, 1'b0, 1);
    tick(1'b1, 1'b0, 1);
    chk("restart_phase0", 32'(phase_active), 32'h1);
    chk("restart_strobe0", 32'(phase_strobe), 32'h1);
    drain();

    // enable and step together: run wins, cycles continue
    tick(1'b1, 1'b1, 0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b0, 0);
      if (cycle_done) nd++;
    end
    chk("priority_done_count", 32'(nd), 32'd3);
    drain();

    // randomized stimulus against the model
    en_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) en_r = ~en_r;
      tick(en_r, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
